// File: rtl/ram_port_arbiter.sv
// Two-port round-robin arbiter in front of a single-port 32-bit block RAM.
// An owner can lock consecutive beats, bounded by MAX_BURST when the other port is waiting.
module ram_port_arbiter #(
    parameter int ADDR_WIDTH = 12,
    parameter int MAX_BURST  = 8
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  we0,
    input  logic                  we1,
    input  logic                  lock0,
    input  logic                  lock1,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [3:0]            be0,
    input  logic [3:0]            be1,
    input  logic [31:0]           wdata0,
    input  logic [31:0]           wdata1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  rvalid0,
    output logic                  rvalid1,
    output logic [31:0]           rdata,
    output logic [ADDR_WIDTH-1:0] ramAddr,
    output logic [3:0]            ramWe,
    output logic [31:0]           ramWdata,
    input  logic [31:0]           ramRdata
);
    localparam int CW = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t          state_q, state_d;
    logic            last_gnt_q, last_gnt_d;
    logic [CW-1:0]   burst_cnt_q, burst_cnt_d;
    logic            rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
    logic            g0, g1, owner_beat, owner_lock, at_limit;

    assign at_limit = (burst_cnt_q == CW'(MAX_BURST));

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q     <= IDLE;
            last_gnt_q  <= 1'b1;
            burst_cnt_q <= '0;
            rvalid0_q   <= 1'b0;
            rvalid1_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_gnt_q  <= last_gnt_d;
            burst_cnt_q <= burst_cnt_d;
            rvalid0_q   <= rvalid0_d;
            rvalid1_q   <= rvalid1_d;
        end
    end

    always_comb begin
        g0          = 1'b0;
        g1          = 1'b0;
        owner_beat  = 1'b0;
        owner_lock  = (state_q == OWN0) ? lock0 : lock1;
        state_d     = IDLE;
        burst_cnt_d = '0;
        last_gnt_d  = last_gnt_q;
        if (!HRESET) begin
            // An owner that dropped its request falls through to plain arbitration.
            if (state_q == OWN0 && req0) begin
                if (at_limit && req1) g1 = 1'b1;
                else begin g0 = 1'b1; owner_beat = 1'b1; end
            end else if (state_q == OWN1 && req1) begin
                if (at_limit && req0) g0 = 1'b1;
                else begin g1 = 1'b1; owner_beat = 1'b1; end
            end else if (req0 && req1) begin
                g0 = last_gnt_q;
                g1 = !last_gnt_q;
            end else begin
                g0 = req0;
                g1 = req1;
            end
        end
        if (g0 || g1) last_gnt_d = g1;
        if (owner_beat) begin
            if (owner_lock) begin
                state_d     = state_q;
                burst_cnt_d = at_limit ? burst_cnt_q : burst_cnt_q + CW'(1);
            end
        end else if (g0 && lock0) begin
            state_d     = OWN0;
            burst_cnt_d = CW'(1);
        end else if (g1 && lock1) begin
            state_d     = OWN1;
            burst_cnt_d = CW'(1);
        end
        rvalid0_d = g0 && !we0;
        rvalid1_d = g1 && !we1;
    end

    always_comb begin
        gnt0     = g0;
        gnt1     = g1;
        rvalid0  = rvalid0_q;
        rvalid1  = rvalid1_q;
        rdata    = ramRdata;
        ramAddr  = '0;
        ramWe    = 4'b0000;
        ramWdata = '0;
        if (g0) begin
            ramAddr  = addr0;
            ramWe    = we0 ? be0 : 4'b0000;
            ramWdata = wdata0;
        end else if (g1) begin
            ramAddr  = addr1;
            ramWe    = we1 ? be1 : 4'b0000;
            ramWdata = wdata1;
        end
    end
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: directed scenarios plus a randomized run against
// an ownership/turn reference model and a write-first byte-masked RAM model.
module tb_ram_port_arbiter;
    localparam int AW = 12;
    localparam int MB = 8;

    logic          HCLK = 1'b0;
    logic          HRESET = 1'b1;
    logic          req0 = 0, req1 = 0, we0 = 0, we1 = 0, lock0 = 0, lock1 = 0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [3:0]    be0 = '0, be1 = '0;
    logic [31:0]   wdata0 = '0, wdata1 = '0;
    logic          gnt0, gnt1, rvalid0, rvalid1;
    logic [31:0]   rdata, ramWdata;
    logic [AW-1:0] ramAddr;
    logic [3:0]    ramWe;
    logic [31:0]   ramRdata = '0;
    logic [31:0]   mem [0:(1<<AW)-1] = '{default: '0};
    logic [31:0]   mref [0:7] = '{default: '0};
    int            total = 0;
    int            bad = 0;

    always #5 HCLK = ~HCLK;

    ram_port_arbiter #(.ADDR_WIDTH(AW), .MAX_BURST(MB)) dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1), .lock0(lock0), .lock1(lock1),
        .addr0(addr0), .addr1(addr1), .be0(be0), .be1(be1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata(rdata),
        .ramAddr(ramAddr), .ramWe(ramWe), .ramWdata(ramWdata), .ramRdata(ramRdata)
    );

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] be,
                                          input logic [31:0] wd);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = wd[b*8 +: 8];
        return r;
    endfunction

    // Write-first single-port RAM with one-cycle registered read.
    always @(posedge HCLK) begin
        mem[ramAddr] <= merge(mem[ramAddr], ramWe, ramWdata);
        ramRdata     <= merge(mem[ramAddr], ramWe, ramWdata);
    end

    task automatic idle_inputs();
        req0 = 0; req1 = 0; we0 = 0; we1 = 0; lock0 = 0; lock1 = 0;
    endtask

    task automatic do_reset();
        @(negedge HCLK); HRESET = 1; idle_inputs();
        @(negedge HCLK); HRESET = 0;
    endtask

    task automatic test_reset();
        @(negedge HCLK); HRESET = 1; req0 = 1; req1 = 1; we0 = 1; we1 = 1; be0 = 4'hF; be1 = 4'hF;
        repeat (2) @(posedge HCLK);
        #1;
        total++; if ({gnt0, gnt1} !== 2'b00) begin bad++; $display("FAIL rst_gnt got=%b%b exp=00", gnt0, gnt1); end
        total++; if (ramWe !== 4'h0) begin bad++; $display("FAIL rst_ramwe got=%h exp=0", ramWe); end
        total++; if ({rvalid0, rvalid1} !== 2'b00) begin bad++; $display("FAIL rst_rvalid got=%b%b exp=00", rvalid0, rvalid1); end
        @(negedge HCLK); HRESET = 0; we0 = 0; we1 = 0; #1;
        total++; if ({gnt0, gnt1} !== 2'b10) begin bad++; $display("FAIL rst_first got=%b%b exp=10", gnt0, gnt1); end
        @(negedge HCLK); idle_inputs(); #1;
        total++; if ({rvalid0, rvalid1} !== 2'b10) begin bad++; $display("FAIL rst_first_rv got=%b%b exp=10", rvalid0, rvalid1); end
    endtask

    task automatic test_write_read();
        @(negedge HCLK); req0 = 1; we0 = 1; addr0 = 12'h005; be0 = 4'b0011; wdata0 = 32'hDEADBEEF; #1;
        total++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin bad++; $display("FAIL wr_gnt got=%b%b exp=10", gnt0, gnt1); end
        total++; if (ramWe !== 4'b0011 || ramAddr !== 12'h005 || ramWdata !== 32'hDEADBEEF) begin
            bad++; $display("FAIL wr_ram got we=%b a=%h d=%h exp we=0011 a=005 d=deadbeef", ramWe, ramAddr, ramWdata); end
        @(negedge HCLK); we0 = 0; #1;
        total++; if (gnt0 !== 1'b1 || ramWe !== 4'h0) begin bad++; $display("FAIL rd_gnt got=%b we=%b exp=1 we=0000", gnt0, ramWe); end
        total++; if (rvalid0 !== 1'b0) begin bad++; $display("FAIL wr_no_rvalid got=%b exp=0", rvalid0); end
        @(negedge HCLK); req0 = 0; #1;
        total++; if (rvalid0 !== 1'b1 || rvalid1 !== 1'b0) begin bad++; $display("FAIL rd_rvalid got=%b%b exp=10", rvalid0, rvalid1); end
        total++; if (rdata !== 32'h0000BEEF) begin bad++; $display("FAIL rd_data got=%h exp=0000beef", rdata); end
        total++; if (ramAddr !== '0 || ramWdata !== '0 || ramWe !== 4'h0) begin bad++; $display("FAIL nogrant_bus got a=%h d=%h we=%b exp zeros", ramAddr, ramWdata, ramWe); end
        @(negedge HCLK); #1;
        total++; if (rvalid0 !== 1'b0) begin bad++; $display("FAIL rv_one_cycle got=%b exp=0", rvalid0); end
    endtask

    task automatic test_round_robin();
        int prev;
        do_reset();
        req0 = 1; req1 = 1; addr0 = 12'h005; addr1 = 12'h005;
        prev = -1;
        for (int i = 0; i < 6; i++) begin
            #1;
            total++; if ({gnt0, gnt1} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
                bad++; $display("FAIL rr_gnt i=%0d got=%b%b exp_port=%0d", i, gnt0, gnt1, i % 2); end
            if (prev >= 0) begin
                total++; if (rvalid0 !== (prev == 0) || rvalid1 !== (prev == 1) || rdata !== 32'h0000BEEF) begin
                    bad++; $display("FAIL rr_rv i=%0d got=%b%b d=%h exp_port=%0d d=0000beef", i, rvalid0, rvalid1, rdata, prev); end
            end
            prev = i % 2;
            @(negedge HCLK);
        end
        idle_inputs(); #1;
        total++; if ({rvalid0, rvalid1} !== 2'b01) begin bad++; $display("FAIL rr_last_rv got=%b%b exp=01", rvalid0, rvalid1); end
    endtask

    task automatic test_lock_bound();
        do_reset();
        req1 = 1; lock1 = 1; we1 = 1; be1 = 4'hF; addr1 = 12'h040; addr0 = 12'h005;
        for (int i = 0; i < 9; i++) begin
            wdata1 = 32'h1000 + i; req0 = (i >= 2);
            #1;
            total++; if (gnt1 !== (i < 8) || gnt0 !== (i == 8)) begin
                bad++; $display("FAIL lock_bound beat=%0d got=%b%b exp=%b%b", i, gnt0, gnt1, i == 8, i < 8); end
            @(negedge HCLK);
        end
        idle_inputs();
    endtask

    task automatic test_lock_alone();
        int miss;
        do_reset();
        req1 = 1; lock1 = 1; addr1 = 12'h041; miss = 0;
        for (int i = 0; i < 20; i++) begin
            #1; if (gnt1 !== 1'b1) miss++;
            @(negedge HCLK);
        end
        total++; if (miss != 0) begin bad++; $display("FAIL lock_alone missed=%0d exp=0", miss); end
        req0 = 1; #1;
        total++; if ({gnt0, gnt1} !== 2'b10) begin bad++; $display("FAIL lock_sat_yield got=%b%b exp=10", gnt0, gnt1); end
        @(negedge HCLK); idle_inputs();
    endtask

    task automatic test_reset_mid_read();
        do_reset();
        req0 = 1; we0 = 0; addr0 = 12'h005; #1;
        total++; if (gnt0 !== 1'b1) begin bad++; $display("FAIL mid_gnt got=%b exp=1", gnt0); end
        #2 HRESET = 1; #1;
        total++; if (gnt0 !== 1'b0 || ramWe !== 4'h0) begin bad++; $display("FAIL mid_rst_gnt got=%b we=%b exp=0", gnt0, ramWe); end
        @(negedge HCLK); HRESET = 0; idle_inputs(); #1;
        total++; if (rvalid0 !== 1'b0) begin bad++; $display("FAIL mid_rv0 got=%b exp=0", rvalid0); end
        @(negedge HCLK); req0 = 1; req1 = 1; #1;
        total++; if (rvalid0 !== 1'b0 || {gnt0, gnt1} !== 2'b10) begin
            bad++; $display("FAIL mid_after got rv=%b g=%b%b exp rv=0 g=10", rvalid0, gnt0, gnt1); end
        @(negedge HCLK); idle_inputs();
    endtask

    task automatic test_dropout();
        do_reset();
        req0 = 1; lock0 = 1; addr0 = 12'h005; #1;
        total++; if ({gnt0, gnt1} !== 2'b10) begin bad++; $display("FAIL drop_own got=%b%b exp=10", gnt0, gnt1); end
        @(negedge HCLK); req1 = 1; addr1 = 12'h006; #1;
        total++; if ({gnt0, gnt1} !== 2'b10) begin bad++; $display("FAIL drop_block got=%b%b exp=10", gnt0, gnt1); end
        @(negedge HCLK); req0 = 0; lock0 = 0; #1;
        total++; if ({gnt0, gnt1} !== 2'b01 || ramAddr !== 12'h006) begin
            bad++; $display("FAIL drop_switch got=%b%b a=%h exp=01 a=006", gnt0, gnt1, ramAddr); end
        @(negedge HCLK); idle_inputs();
    endtask

    task automatic test_random();
        int          own, cnt, last, g;
        logic        cr[2], cw[2], cl[2], pend[2];
        int          ca[2];
        logic [3:0]  cb[2], ewe;
        logic [31:0] cd[2], exp_rd;
        logic [1:0]  exp_rv;
        int          errs;
        do_reset();
        own = -1; cnt = 0; last = 1; exp_rv = 2'b00; exp_rd = '0; errs = 0;
        pend[0] = 0; pend[1] = 0;
        for (int n = 0; n < 400; n++) begin
            for (int p = 0; p < 2; p++) if (!pend[p]) begin
                cr[p] = ($urandom_range(3) != 0); cw[p] = 1'($urandom_range(1));
                cl[p] = ($urandom_range(3) != 0); ca[p] = $urandom_range(7);
                cb[p] = 4'($urandom_range(15)); cd[p] = $urandom;
            end
            req0 = cr[0]; we0 = cw[0]; lock0 = cl[0]; addr0 = 12'h100 + 12'(ca[0]); be0 = cb[0]; wdata0 = cd[0];
            req1 = cr[1]; we1 = cw[1]; lock1 = cl[1]; addr1 = 12'h100 + 12'(ca[1]); be1 = cb[1]; wdata1 = cd[1];
            #1;
            // Owner keeps its turn unless it has used MB beats and the other side waits.
            g = -1;
            if (own >= 0 && cr[own]) g = (cnt == MB && cr[1-own]) ? 1 - own : own;
            else if (cr[0] && cr[1]) g = 1 - last;
            else if (cr[0]) g = 0;
            else if (cr[1]) g = 1;
            total++; if (gnt0 !== (g == 0) || gnt1 !== (g == 1)) begin
                bad++; errs++; if (errs < 10) $display("FAIL rnd_gnt n=%0d got=%b%b exp_port=%0d", n, gnt0, gnt1, g); end
            ewe = (g >= 0 && cw[g]) ? cb[g] : 4'h0;
            total++; if (ramWe !== ewe || ramAddr !== ((g >= 0) ? 12'h100 + 12'(ca[g]) : 12'h000) ||
                         ramWdata !== ((g >= 0) ? cd[g] : 32'h0)) begin
                bad++; errs++; if (errs < 10) $display("FAIL rnd_bus n=%0d got we=%b a=%h d=%h exp we=%b", n, ramWe, ramAddr, ramWdata, ewe); end
            total++; if ({rvalid1, rvalid0} !== exp_rv || (exp_rv != 0 && rdata !== exp_rd)) begin
                bad++; errs++; if (errs < 10) $display("FAIL rnd_rv n=%0d got=%b%b d=%h exp=%b%b d=%h", n, rvalid0, rvalid1, rdata, exp_rv[0], exp_rv[1], exp_rd); end
            @(posedge HCLK);
            exp_rv = 2'b00;
            if (g >= 0) begin
                if (cw[g]) mref[ca[g]] = merge(mref[ca[g]], cb[g], cd[g]);
                else begin exp_rv[g] = 1'b1; exp_rd = mref[ca[g]]; end
                if (g == own && cl[g]) cnt = (cnt < MB) ? cnt + 1 : MB;
                else if (g != own && cl[g]) begin own = g; cnt = 1; end
                else begin own = -1; cnt = 0; end
                last = g;
            end else begin
                own = -1; cnt = 0;
            end
            for (int p = 0; p < 2; p++) pend[p] = cr[p] && (g != p);
            @(negedge HCLK);
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_round_robin();
        test_lock_bound();
        test_lock_alone();
        test_reset_mid_read();
        test_dropout();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
